// File: rtl/long_latency_scoreboard.sv
// Register scoreboard for long-latency results (loads, mul/div) in the 5-stage RV32I pipeline.
// Holds decode while a source or destination register still awaits a non-forwardable result.
module long_latency_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_long,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic             sb_error
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [31:0]      pending_q;
    logic [31:0]      pending_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             err_q;

    logic wb_bit;
    logic wb_clear;
    logic wb_spurious;
    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;
    logic long_op;
    logic raw;
    logic waw;
    logic full;
    logic set_ev;
    logic overflow;
    logic underflow;

    // A write-back this cycle already reaches decode through the WB bypass, so it no longer counts as a hit.
    assign wb_bit      = pending_q[wb_rd];
    assign wb_clear    = wb_valid && (wb_rd != 5'd0) && wb_bit;
    assign wb_spurious = wb_valid && (wb_rd != 5'd0) && !wb_bit;

    assign hit_rs1 = pending_q[id_rs1]   && !(wb_valid && wb_rd == id_rs1);
    assign hit_rs2 = pending_q[id_rs2]   && !(wb_valid && wb_rd == id_rs2);
    assign hit_rd  = pending_q[issue_rd] && !(wb_valid && wb_rd == issue_rd);

    // A long op targeting x0 produces nothing to track, so it behaves like a short op.
    assign long_op = issue_long && (issue_rd != 5'd0);

    assign raw  = (id_uses_rs1 && hit_rs1) || (id_uses_rs2 && hit_rs2);
    assign waw  = long_op && hit_rd;
    assign full = long_op && (cnt_q == MAX_CNT) && !wb_clear;

    assign stall      = issue_valid && (raw || waw || full);
    assign issue_fire = issue_valid && !stall;
    assign set_ev     = issue_fire && long_op;

    assign overflow  = set_ev && !wb_clear && (cnt_q == MAX_CNT);
    assign underflow = wb_clear && !set_ev && (cnt_q == '0);

    // Clear first, then set, so a same-register issue and write-back leaves the bit set.
    always_comb begin
        pending_next = pending_q;
        if (wb_clear) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (set_ev) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = cnt_q;
        if (set_ev && !wb_clear) begin
            cnt_next = cnt_q + CNT_W'(1);
        end else if (wb_clear && !set_ev) begin
            cnt_next = cnt_q - CNT_W'(1);
        end
    end

    // Flush wipes outstanding work but keeps any recorded error; counter faults freeze state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (flush) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (overflow || underflow) begin
                err_q <= 1'b1;
            end else begin
                pending_q <= pending_next;
                cnt_q     <= cnt_next;
            end
            if (wb_spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending      = pending_q;
    assign inflight_cnt = cnt_q;
    assign sb_error     = err_q;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Self-checking bench for long_latency_scoreboard: directed vector table, a reset sequence,
// then randomized traffic compared against a set-of-registers reference model.
module tb_long_latency_scoreboard;

    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef struct {
        logic        rst;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        iv;
        logic [4:0]  ird;
        logic        il;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_pend;
        int          exp_cnt;
        logic        exp_err;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_long;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             flush;
    logic             stall;
    logic             issue_fire;
    logic [31:0]      pending;
    logic [CNT_W-1:0] inflight_cnt;
    logic             sb_error;

    int tests;
    int fails;

    // Reference model: the set of registers awaiting a long-latency result, plus the sticky error.
    bit [31:0] model_set;
    bit        model_err;

    long_latency_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk),
        .rst(rst),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_long(issue_long),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .flush(flush),
        .stall(stall),
        .issue_fire(issue_fire),
        .pending(pending),
        .inflight_cnt(inflight_cnt),
        .sb_error(sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic iv,
                                input logic [4:0] ird, input logic il, input logic wv,
                                input logic [4:0] wrd, input logic fl, input logic es,
                                input logic [31:0] ep, input int ec, input logic ee);
        vec_t v;
        v.rst = 1'b0;  v.rs1 = rs1; v.u1 = u1; v.rs2 = 5'd0; v.u2 = 1'b0;
        v.iv = iv;     v.ird = ird; v.il = il; v.wv = wv;   v.wrd = wrd; v.fl = fl;
        v.exp_stall = es; v.exp_pend = ep; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        id_rs1      = v.rs1;
        id_uses_rs1 = v.u1;
        id_rs2      = v.rs2;
        id_uses_rs2 = v.u2;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        issue_long  = v.il;
        wb_valid    = v.wv;
        wb_rd       = v.wrd;
        flush       = v.fl;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle: combinational outputs checked before the edge, registered ones just after.
    task automatic runVector(input vec_t v, input int idx);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput("stall", idx, {31'd0, stall}, {31'd0, v.exp_stall});
        checkOutput("issue_fire", idx, {31'd0, issue_fire}, {31'd0, v.iv && !v.exp_stall});
        @(posedge clk);
        #1;
        checkOutput("pending", idx, pending, v.exp_pend);
        checkOutput("inflight_cnt", idx, 32'(inflight_cnt), 32'(v.exp_cnt));
        checkOutput("sb_error", idx, {31'd0, sb_error}, {31'd0, v.exp_err});
    endtask

    function automatic bit waiting(input logic [4:0] r, input vec_t v);
        return model_set[r] && !(v.wv && v.wrd == r);
    endfunction

    // Fill in expected values from the model, then advance the model by one cycle.
    function automatic vec_t predict(input vec_t v);
        vec_t o;
        bit   long_real;
        bit   retiring;
        bit   fire;
        o = v;
        long_real = v.il && (v.ird != 5'd0);
        retiring  = v.wv && (v.wrd != 5'd0) && model_set[v.wrd];
        o.exp_stall = v.iv && ((v.u1 && waiting(v.rs1, v)) || (v.u2 && waiting(v.rs2, v)) ||
                               (long_real && waiting(v.ird, v)) ||
                               (long_real && $countones(model_set) == MAX_INFLIGHT && !retiring));
        fire = v.iv && !o.exp_stall;
        if (v.rst) begin
            model_set = '0;
            model_err = 1'b0;
        end else if (v.fl) begin
            model_set = '0;
        end else begin
            if (v.wv && v.wrd != 5'd0) begin
                if (model_set[v.wrd]) model_set[v.wrd] = 1'b0;
                else                  model_err = 1'b1;
            end
            if (fire && long_real) model_set[v.ird] = 1'b1;
        end
        o.exp_pend = model_set;
        o.exp_cnt  = $countones(model_set);
        o.exp_err  = model_err;
        return o;
    endfunction

    vec_t tbl[26];

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        model_set = '0;
        model_err = 1'b0;

        // Load-use on x5
        tbl[0]  = mk(5'd0, 0, 1, 5'd5,  1, 0, 5'd0,  0, 0, 32'h20,  1, 0);
        tbl[1]  = mk(5'd5, 1, 1, 5'd6,  0, 0, 5'd0,  0, 1, 32'h20,  1, 0);
        tbl[2]  = mk(5'd5, 1, 1, 5'd6,  0, 0, 5'd0,  0, 1, 32'h20,  1, 0);
        tbl[3]  = mk(5'd5, 1, 1, 5'd6,  0, 1, 5'd5,  0, 0, 32'h0,   0, 0);
        // Fill to capacity, then retire x2 while issuing x6
        tbl[4]  = mk(5'd0, 0, 1, 5'd1,  1, 0, 5'd0,  0, 0, 32'h2,   1, 0);
        tbl[5]  = mk(5'd0, 0, 1, 5'd2,  1, 0, 5'd0,  0, 0, 32'h6,   2, 0);
        tbl[6]  = mk(5'd0, 0, 1, 5'd3,  1, 0, 5'd0,  0, 0, 32'hE,   3, 0);
        tbl[7]  = mk(5'd0, 0, 1, 5'd4,  1, 0, 5'd0,  0, 0, 32'h1E,  4, 0);
        tbl[8]  = mk(5'd0, 0, 1, 5'd6,  1, 0, 5'd0,  0, 1, 32'h1E,  4, 0);
        tbl[9]  = mk(5'd0, 0, 1, 5'd6,  1, 1, 5'd2,  0, 0, 32'h5A,  4, 0);
        tbl[10] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd1,  0, 0, 32'h58,  3, 0);
        tbl[11] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd3,  0, 0, 32'h50,  2, 0);
        tbl[12] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd4,  0, 0, 32'h40,  1, 0);
        tbl[13] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd6,  0, 0, 32'h0,   0, 0);
        // WAW on x7, then same-cycle issue and write-back
        tbl[14] = mk(5'd0, 0, 1, 5'd7,  1, 0, 5'd0,  0, 0, 32'h80,  1, 0);
        tbl[15] = mk(5'd0, 0, 1, 5'd7,  1, 0, 5'd0,  0, 1, 32'h80,  1, 0);
        tbl[16] = mk(5'd0, 0, 1, 5'd7,  1, 1, 5'd7,  0, 0, 32'h80,  1, 0);
        tbl[17] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd7,  0, 0, 32'h0,   0, 0);
        // x0 is never tracked
        tbl[18] = mk(5'd0, 1, 1, 5'd0,  1, 0, 5'd0,  0, 0, 32'h0,   0, 0);
        // Flush with a concurrent issue, then flush with a stray write-back
        tbl[19] = mk(5'd0, 0, 1, 5'd3,  1, 0, 5'd0,  0, 0, 32'h8,   1, 0);
        tbl[20] = mk(5'd0, 0, 1, 5'd8,  1, 0, 5'd0,  0, 0, 32'h108, 2, 0);
        tbl[21] = mk(5'd0, 0, 1, 5'd10, 1, 0, 5'd0,  1, 0, 32'h0,   0, 0);
        tbl[22] = mk(5'd0, 0, 1, 5'd9,  1, 0, 5'd0,  0, 0, 32'h200, 1, 0);
        tbl[23] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd12, 1, 0, 32'h0,   0, 0);
        // Spurious write-back sets a sticky error
        tbl[24] = mk(5'd0, 0, 0, 5'd0,  0, 1, 5'd9,  0, 0, 32'h0,   0, 1);
        tbl[25] = mk(5'd0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 32'h0,   0, 1);

        applyStimulus(mk_rst());
        runVector(mk_rst(), 100);
        runVector(mk_rst(), 101);

        for (int i = 0; i < 26; i++) begin
            runVector(tbl[i], i);
        end

        // Reset clears the error; reset mid-operation makes a late write-back spurious.
        runVector(mk_rst(), 200);
        runVector(mk(5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 32'h20, 1, 0), 201);
        runVector(mk_rst(), 202);
        runVector(mk(5'd5, 1, 0, 5'd0, 0, 1, 5'd5, 0, 0, 32'h0, 0, 1), 203);
        runVector(mk_rst(), 204);

        model_set = '0;
        model_err = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int start;
            v = mk(5'($urandom_range(0, 7)), 1'($urandom % 2), 1'($urandom % 4 != 0),
                   5'($urandom_range(0, 7)), 1'($urandom % 2), 1'($urandom % 3 == 0),
                   5'($urandom_range(0, 7)), 1'($urandom % 50 == 0), 0, 32'h0, 0, 0);
            v.rs2 = 5'($urandom_range(0, 7));
            v.u2  = 1'($urandom % 2);
            v.rst = 1'($urandom % 200 == 0);
            // Steer most write-backs onto a register that is actually outstanding.
            if (v.wv && ($urandom % 8 != 0)) begin
                start = int'(v.wrd);
                for (int k = 0; k < 8; k++) begin
                    if (model_set[(start + k) % 8]) begin
                        v.wrd = 5'((start + k) % 8);
                        break;
                    end
                end
            end
            v = predict(v);
            runVector(v, 1000 + n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/long_latency_scoreboard.md
# long_latency_scoreboard

Register scoreboard for the 5-stage RV32I pipeline, working alongside the forwarding unit. It records which destination registers have a result outstanding from a long-latency operation (load, multi-cycle mul/div) whose value is not yet forwardable. It holds the decode stage while a source or destination register is still outstanding. Entries retire when the producing operation writes back, so the forwarding path can take over.

## Interface
Parameters:
- MAX_INFLIGHT, 4, maximum concurrently outstanding long-latency ops (1..31)
- CNT_W, $clog2(MAX_INFLIGHT+1), width of the in-flight counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_rs1  input  5  decode-stage source 1
- id_rs2  input  5  decode-stage source 2
- id_uses_rs1  input  1  instruction reads rs1
- id_uses_rs2  input  1  instruction reads rs2
- issue_valid  input  1  decode instruction wants to advance to EX
- issue_rd  input  5  its destination register
- issue_long  input  1  it is a long-latency op that writes issue_rd
- wb_valid  input  1  a long-latency op is writing back this cycle
- wb_rd  input  5  its destination register
- flush  input  1  squash all outstanding long-latency ops
- stall  output  1  hold decode; combinational
- issue_fire  output  1  issue_valid && !stall; combinational
- pending  output  32  registered outstanding-write mask; bit 0 always 0
- inflight_cnt  output  CNT_W  registered outstanding-op count
- sb_error  output  1  sticky protocol-error flag

## Operation
Hazard terms are combinational from registered state and current inputs. `hit(r)` means `pending[r] && !(wb_valid && wb_rd == r)`. The write-back in the same cycle is covered by the forwarding unit's WB bypass.
- RAW: `id_uses_rs1 && hit(id_rs1)`, or `id_uses_rs2 && hit(id_rs2)`.
- WAW: `issue_long && hit(issue_rd)`.
- FULL: `issue_long && inflight_cnt == MAX_INFLIGHT && !wb_clear`. Here `wb_clear` = wb_valid with `pending[wb_rd]` set and wb_rd != 0.
- stall = issue_valid && (RAW || WAW || FULL). stall is 0 when issue_valid = 0.

Register x0:
- x0 is never marked pending.
- issue_rd = 0 with issue_long still counts as an issue for the in-flight count only if rd != 0. Otherwise it is treated as a short op.

Set and clear events at the rising edge:
- set = issue_fire && issue_long && issue_rd != 0.
- clear = wb_clear.

Updates:
- pending: clear bit wb_rd, then set bit issue_rd. Set wins if the registers are equal.
- inflight_cnt += set − clear. The result is always within 0..MAX_INFLIGHT.

Protocol errors (sb_error set, sticky until rst):
- wb_valid with wb_rd != 0 and `pending[wb_rd]` clear. The write-back is otherwise ignored.
- Counter underflow or overflow would occur. The count saturates and state is otherwise unchanged.

flush:
- Takes priority over set and clear.
- Next cycle pending = 0 and inflight_cnt = 0.
- sb_error is unaffected.
- A wb_valid in the flush cycle raises no error.

## Timing
- Reset (rst high at an edge): pending = 0, inflight_cnt = 0, sb_error = 0. stall = 0 after reset when no hazard exists.
- Set latency: pending bit and count visible 1 cycle after the issue_fire edge. The next instruction in decode sees it immediately.
- Clear latency: same-cycle for hazard purposes via the wb bypass term. The registered bit drops 1 cycle after the wb_valid edge.
- The stall path is purely combinational: no registered stall, no bubble beyond hazard duration.
- rst asserted mid-operation discards all outstanding state. Late write-backs after reset flag sb_error.
- Simultaneous issue and wb to the same rd: the bit stays set and the count is unchanged.

## Test plan
- Load-use: issue long to x5, then next cycle id_rs1=5. Required: stall=1 each cycle until wb_valid/wb_rd=5. In the wb cycle stall=0; next cycle pending[5]=0 and inflight_cnt=0.
- Full: MAX_INFLIGHT=4; issue long to x1..x4 on consecutive cycles, then long to x6. Required: stall=1 for x6. In the cycle wb_rd=2 is presented, stall=0 and issue_fire=1; inflight_cnt stays 4.
- WAW and same-cycle: x7 pending. Issue long to x7 with no wb: stall=1. Issue long to x7 with wb_rd=7 the same cycle: stall=0; pending[7] stays 1, count unchanged.
- x0: issue long to x0 with id_rs1=0 reads. Required: stall=0, pending=0, inflight_cnt=0.
- Spurious wb: wb_valid with wb_rd=9 while pending[9]=0. Required: sb_error=1 next cycle and stays 1. After rst: sb_error=0, pending=0.
- Flush: x3 and x8 pending, flush=1 together with issue of long to x10. Required: next cycle pending=0, inflight_cnt=0.
